// File: rtl/join_n_buffered_pkg.sv
// rtl/join_n_buffered_pkg.sv - default sizing shared by the join_n_buffered slice
package join_n_buffered_pkg;

  localparam int unsigned DEFAULT_N          = 10;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/join_slot.sv
// rtl/join_slot.sv - one-entry holding register for a single join input stream
module join_slot #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  reload,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] q
);

  // reload wins over clear: a beat arriving on the join cycle refills the slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (reload) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load || reload) begin
      q <= data;
    end
  end

endmodule

// File: rtl/join_n_buffered.sv
// rtl/join_n_buffered.sv - N-to-1 stream join with per-stream slots and a registered output
module join_n_buffered
  import join_n_buffered_pkg::*;
#(
  parameter int unsigned N          = DEFAULT_N,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0][DATA_WIDTH-1:0] data_in,
  input  logic [N-1:0]                 data_in_valid,
  output logic [N-1:0]                 data_in_ready,
  output logic [N*DATA_WIDTH-1:0]      data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic [N-1:0]                 slot_full
);

  logic [N-1:0][DATA_WIDTH-1:0] slot_data;
  logic [N*DATA_WIDTH-1:0]      out_data;
  logic                         out_valid;
  logic                         join_fire;

  // Output register frees up either when empty or when being drained this cycle
  assign join_fire     = (&slot_full) && (!out_valid || data_out_ready);
  assign data_in_ready = ~slot_full | {N{join_fire}};

  for (genvar i = 0; i < N; i++) begin : g_slot
    join_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (!join_fire && data_in_valid[i] && !slot_full[i]),
      .clear (join_fire && !data_in_valid[i]),
      .reload(join_fire && data_in_valid[i]),
      .data  (data_in[i]),
      .full  (slot_full[i]),
      .q     (slot_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
    end else if (join_fire) begin
      out_valid <= 1'b1;
    end else if (data_out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Packed slot array flattens with stream 0 in the low bits
  always_ff @(posedge clk) begin
    if (join_fire) begin
      out_data <= slot_data;
    end
  end

  assign data_out       = out_data;
  assign data_out_valid = out_valid;

endmodule

// File: tb/tb_join_n_buffered.sv
// tb/tb_join_n_buffered.sv - directed self-checking bench for join_n_buffered
module tb_join_n_buffered;

  localparam int N  = 10;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0][DW-1:0] din;
  logic [N-1:0]         din_valid;
  logic [N-1:0]         din_ready;
  logic [N*DW-1:0]      dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic [N-1:0]         slot_full;

  logic [0:0][DW-1:0]   din1;
  logic [0:0]           din1_valid;
  logic [0:0]           din1_ready;
  logic [DW-1:0]        dout1;
  logic                 dout1_valid;
  logic                 dout1_ready;
  logic [0:0]           slot1_full;

  int n_checks = 0;
  int n_errors = 0;
  int cnt[N];
  int out_k;
  int limit;
  bit sb_en;
  logic [N-1:0] mask;
  logic [N*DW-1:0] exp_v;

  always #5 clk = ~clk;

  join_n_buffered #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(din_valid),
    .data_in_ready(din_ready), .data_out(dout), .data_out_valid(dout_valid),
    .data_out_ready(dout_ready), .slot_full(slot_full)
  );

  join_n_buffered #(.N(1), .DATA_WIDTH(DW)) dut1 (
    .clk(clk), .rst(rst), .data_in(din1), .data_in_valid(din1_valid),
    .data_in_ready(din1_ready), .data_out(dout1), .data_out_valid(dout1_valid),
    .data_out_ready(dout1_ready), .slot_full(slot1_full)
  );

  task automatic check(input string tag, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshakes are bookkept at the falling edge, inputs change just after the rising edge
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (din_valid[i] && din_ready[i]) cnt[i]++;
    if (sb_en && dout_valid && dout_ready) begin
      for (int i = 0; i < N; i++) exp_v[i*DW +: DW] = DW'(i*256 + out_k);
      check($sformatf("beat%0d", out_k), dout, exp_v);
      out_k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      din[i]       = DW'(i*256 + cnt[i]);
      din_valid[i] = mask[i] && (cnt[i] < limit);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    din = '0; din_valid = '0; dout_ready = 1'b1;
    din1 = '0; din1_valid = '0; dout1_ready = 1'b1;
    mask = '0; sb_en = 1'b0; limit = 1000; out_k = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic run_until(input int target, input bit rnd);
    int cyc = 0;
    while (out_k < target && cyc < 5000) begin
      mask       = rnd ? N'($urandom) : '1;
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      apply();
      tick();
      cyc++;
    end
    if (out_k < target) check("run_timeout", N*DW'(out_k), N*DW'(target));
  endtask

  initial begin
    // all streams valid together, data_in[i] = i
    do_reset();
    #1;
    check("rst_out_valid", dout_valid, 0);
    check("rst_slot_full", slot_full, 0);
    check("rst_ready", din_ready, {N{1'b1}});
    for (int i = 0; i < N; i++) din[i] = DW'(i);
    din_valid = '1;
    tick();
    din_valid = '0; #1;
    check("lat_c1_valid", dout_valid, 0);
    tick();
    check("lat_c2_valid", dout_valid, 1);
    for (int i = 0; i < N; i++) exp_v[i*DW +: DW] = DW'(i);
    check("lat_c2_data", dout, exp_v);
    tick();
    check("lat_c3_ready", din_ready, {N{1'b1}});
    check("lat_c3_valid", dout_valid, 0);

    // skew: stream 0 in cycle 0, the rest in cycle 5
    do_reset();
    din = '0; din[0] = 16'h00A5; din_valid = 10'h001;
    tick();
    for (int c = 1; c <= 7; c++) begin
      din_valid = (c == 5) ? 10'h3FE : '0;
      #1;
      if (c <= 5) begin
        check($sformatf("skew_c%0d_ready0", c), din_ready[0], 0);
        check($sformatf("skew_c%0d_full", c), slot_full, 10'h001);
      end
      if (c == 6) check("skew_c6_valid", dout_valid, 0);
      if (c == 7) begin
        check("skew_c7_valid", dout_valid, 1);
        check("skew_c7_d0", dout[DW-1:0], 16'h00A5);
      end
      tick();
    end

    // backpressure: ready low for 6 cycles with every stream valid
    do_reset();
    sb_en = 1'b1; mask = '1; dout_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      apply();
      if (c >= 2) check($sformatf("bp_c%0d_ready", c), din_ready, 0);
      tick();
    end
    for (int i = 0; i < N; i++) check($sformatf("bp_taken%0d", i), cnt[i], 2);
    dout_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply();
      check($sformatf("bp_rel%0d_valid", c), dout_valid, 1);
      tick();
    end
    check("bp_order", out_k, 3);

    // streaming with random gaps and backpressure
    do_reset();
    sb_en = 1'b1; limit = 100;
    run_until(100, 1'b1);
    for (int i = 0; i < N; i++) check($sformatf("str_cnt%0d", i), cnt[i], 100);
    dout_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply();
      check($sformatf("str_extra%0d", c), dout_valid, 0);
      tick();
    end

    // reset mid-operation with slots 0-4 full and output pending
    do_reset();
    sb_en = 1'b1; mask = '1; dout_ready = 1'b0;
    apply(); tick();
    mask = 10'h01F;
    apply(); tick();
    mask = '0;
    apply();
    check("mid_pre_full", slot_full, 10'h01F);
    check("mid_pre_valid", dout_valid, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1; #1;
    check("mid_valid", dout_valid, 0);
    check("mid_full", slot_full, 0);
    check("mid_ready", din_ready, {N{1'b1}});
    for (int i = 0; i < N; i++) cnt[i] = 0;
    out_k = 0;
    run_until(5, 1'b0);

    // N = 1 pipeline, data_out is data_in delayed by two
    do_reset();
    for (int c = 0; c < 10; c++) begin
      din1[0] = 16'h1000 + 16'(c); din1_valid = 1'b1; dout1_ready = 1'b1;
      #1;
      if (c >= 2) begin
        check($sformatf("n1_c%0d_valid", c), dout1_valid, 1);
        check($sformatf("n1_c%0d_data", c), dout1, 16'h1000 + 16'(c - 2));
      end else begin
        check($sformatf("n1_c%0d_valid", c), dout1_valid, 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/join_n_buffered.md
Name: join_n_buffered

Overview:
- N-to-1 streaming join: the converging counterpart of the team's 1-to-N split handshake.
- Each of N input streams is captured independently into a one-entry slot, so inputs need not be valid in the same cycle.
- Once all N slots hold a beat, the beats are concatenated into one registered output beat.
- Sits where parallel branches (e.g. after a split) reconverge before a downstream consumer.

Parameters:
- N, 10, number of input streams; N >= 1.
- DATA_WIDTH, 8, bits per input beat.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low (rst == 0 resets on the next clk edge).
- data_in  input  N x DATA_WIDTH  packed array; element i belongs to stream i.
- data_in_valid  input  N  per-stream valid.
- data_in_ready  output  N  per-stream ready.
- data_out  output  N*DATA_WIDTH  concatenated beat; stream i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- data_out_valid  output  1  output valid.
- data_out_ready  input  1  output ready.
- slot_full  output  N  debug: slot i currently holds a beat.

Behaviour:
- Handshake is the standard valid/ready. A transfer occurs on a clk edge where valid && ready. data_out_valid and data_out are held until accepted; no combinational path from data_out_ready to data_out_valid.
- State per stream i: slot_full[i] and slot_data[i]. Output stage: out_valid and out_data registers.
- join_fire = (&slot_full) && (!out_valid || data_out_ready).
- data_in_ready[i] = !slot_full[i] || join_fire. This is combinational from data_out_ready, and must not depend on data_in_valid.
- Slot update, in priority order:
  - On join_fire, slot i is reloaded if data_in_valid[i] (slot_full[i] stays 1, slot_data[i] takes data_in[i]); otherwise it is cleared.
  - Without join_fire, a valid && ready beat sets slot_full[i] and loads slot_data[i].
  - A full slot without join_fire holds its value.
- Output update:
  - On join_fire: out_valid <= 1, out_data <= concatenation of slot_data.
  - Else if data_out_ready: out_valid <= 0.
  - Else: hold.
- Latency:
  - All inputs valid in cycle 0 gives data_out_valid asserted in cycle 2, with data_out_ready held high.
  - Skewed inputs: data_out_valid rises 2 cycles after the last slot fills.
- Throughput: one joined beat per cycle sustained when all inputs are valid every cycle and data_out_ready is high.
- Backpressure:
  - data_out_ready low with out_valid high and all slots full: no join_fire, all data_in_ready low.
  - A slot that is full stalls its own stream while the other streams keep filling.
- Ordering: beat k of every stream lands in joined beat k. No reordering or dropping.
- Reset (rst == 0 at an edge): slot_full = 0, out_valid = 0, data_out_valid = 0. data_in_ready becomes all-ones as a consequence of empty slots. Data registers need not be reset. Reset mid-operation discards all captured beats and the pending output.
- N == 1: same logic; degenerates to a 2-deep pipeline (slot plus output register).

Decomposition:
- No shared-package typedefs are required; the slot-array and output widths are derived locally from N and DATA_WIDTH.
- One natural sub-module, join_slot: a one-entry holding register with inputs load, clear, reload and data. It is instantiated N times in a generate loop.
- The top level contains join_fire, the ready computation and the output register.

Test Plan:
- Reset then all 10 streams valid with data_in[i] = i in one cycle, data_out_ready high:
  - data_out_valid is high 2 cycles later.
  - data_out element i == i.
  - After acceptance, data_in_ready returns to all ones.
- Skew: stream 0 valid (0xA5) in cycle 0; streams 1..9 valid in cycle 5:
  - data_in_ready[0] is low in cycles 1-5.
  - slot_full == 0x001 in cycles 1-5.
  - data_out_valid first rises in cycle 7.
- Backpressure: data_out_ready low for 6 cycles with every stream valid every cycle:
  - Exactly 2 joined beats are buffered (output register plus slots).
  - data_in_ready stays all-zero while stalled.
  - On release, beats 0, 1, 2 emerge in order with no gap.
- Streaming: 100 beats per stream (stream i carries i*256 + k), random per-stream valid gaps, random data_out_ready:
  - Scoreboard sees joined beat k == {i*256 + k} for all i.
  - No loss, no duplication.
- Reset mid-operation: slots 0-4 full and out_valid high, then rst low for 1 cycle:
  - Next cycle data_out_valid = 0, slot_full = 0 and data_in_ready = all ones.
  - The following beats join correctly.
- N = 1, DATA_WIDTH = 16, continuous valid and ready:
  - One beat out per cycle at 2-cycle latency.
  - data_out equals data_in delayed by 2.
